// File: rtl/ahb_slave_mem_interface_if.sv
// AHB-lite bus bundle between a master and the word-addressed memory slave.
// The slave modport receives address/control/write data and returns the response.
interface ahb_slave_mem_interface_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, hwrite, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_slave_mem_interface.sv
// AHB-lite slave backed by a small word memory, with a fixed number of wait
// states per OKAY transfer and the two-cycle ERROR response for bad addresses.
module ahb_slave_mem_interface #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input logic                        hclk,
    input logic                        hreset,
    ahb_slave_mem_interface_if.slave   bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [31:0]        mem_q [DEPTH];

    logic               mem_we;
    logic               can_accept;
    logic               valid_trans;
    logic               accept;
    logic               addr_err;
    logic               rsp_ready;
    logic [1:0]         rsp_resp;
    logic [31:0]        rsp_rdata;

    // Only states that drive hready high can open a new address phase.
    assign can_accept  = (state_q == S_IDLE) || (state_q == S_ACCESS) || (state_q == S_ERR2);
    assign valid_trans = (bus.htrans == 2'b10) || (bus.htrans == 2'b11);
    assign accept      = can_accept && bus.hsel && valid_trans;
    assign addr_err    = (bus.haddr[1:0] != 2'b00) || (bus.haddr[31:2] >= 30'(DEPTH));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        mem_we     = 1'b0;
        rsp_ready  = 1'b1;
        rsp_resp   = 2'b00;
        rsp_rdata  = '0;

        case (state_q)
            S_WAIT: begin
                rsp_ready = 1'b0;
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (write_q) begin
                    mem_we = 1'b1;
                end else begin
                    rsp_rdata = mem_q[idx_q];
                end
            end
            S_ERR1: begin
                rsp_ready = 1'b0;
                rsp_resp  = 2'b01;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                rsp_resp = 2'b01;
            end
            default: begin
            end
        endcase

        // A pipelined address phase overrides the default return to idle.
        if (can_accept) begin
            if (accept) begin
                idx_d      = bus.haddr[IDX_W+1:2];
                write_d    = bus.hwrite;
                wait_cnt_d = WAIT_LOAD;
                if (addr_err) begin
                    state_d = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ACCESS;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            if (mem_we) begin
                mem_q[idx_q] <= bus.hwdata;
            end
        end
    end

    assign bus.hready = rsp_ready;
    assign bus.hresp  = rsp_resp;
    assign bus.hrdata = rsp_rdata;

endmodule
